// File: rtl/vedic_8x8.sv
// Unsigned 8x8 Vedic (Urdhva-Tiryagbhyam) multiplier with a registered 16-bit product.
// The core is built as 2x2 -> 4x4 -> 8x8 cells joined by ripple-carry adders.

module vedic_ha (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

// Ripple-carry adder with no carry-out; callers zero-extend operands so the top carry is never lost.
module vedic_rca #(
   parameter int W = 4
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] s
);
   logic [W-1:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign s[i] = x[i] ^ y[i] ^ c[i];
      if (i < W - 1) begin : g_carry
         assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
      end
   end
endmodule

module vedic_2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);
   logic cross_c;

   assign p[0] = a[0] & b[0];

   vedic_ha u_ha_cross (
      .x (a[1] & b[0]),
      .y (a[0] & b[1]),
      .s (p[1]),
      .c (cross_c)
   );

   vedic_ha u_ha_high (
      .x (a[1] & b[1]),
      .y (cross_c),
      .s (p[2]),
      .c (p[3])
   );
endmodule

module vedic_4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   logic [3:0] q0, q1, q2, q3;
   logic [4:0] mid_sum;
   logic [5:0] upper_sum;

   vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
   vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
   vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
   vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

   // Both crosswise terms share weight 4; add them first, then fold into {q3, q0[3:2]}.
   vedic_rca #(.W(5)) u_add_mid (
      .x ({1'b0, q1}),
      .y ({1'b0, q2}),
      .s (mid_sum)
   );

   vedic_rca #(.W(6)) u_add_upper (
      .x ({q3, q0[3:2]}),
      .y ({1'b0, mid_sum}),
      .s (upper_sum)
   );

   assign p = {upper_sum, q0[1:0]};
endmodule

module vedic_8x8_core (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [7:0]  q0, q1, q2, q3;
   logic [8:0]  mid_sum;
   logic [11:0] upper_sum;

   vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
   vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
   vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
   vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));

   vedic_rca #(.W(9)) u_add_mid (
      .x ({1'b0, q1}),
      .y ({1'b0, q2}),
      .s (mid_sum)
   );

   // The low nibble of q0 passes straight through; everything above it sums in 12 bits.
   vedic_rca #(.W(12)) u_add_upper (
      .x ({q3, q0[7:4]}),
      .y ({3'b000, mid_sum}),
      .s (upper_sum)
   );

   assign p = {upper_sum, q0[3:0]};
endmodule

module vedic_8x8 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] result
);
   logic [15:0] core_product;

   vedic_8x8_core u_core (
      .a (a),
      .b (b),
      .p (core_product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= 16'h0000;
      end else begin
         result <= core_product;
      end
   end
endmodule

// File: tb/tb_vedic_8x8.sv
// Self-checking bench for vedic_8x8: directed, corner, random pipelined, async reset and exhaustive products.

module tb_vedic_8x8;
   logic        clk;
   logic        rst_n;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] result;

   int vectors;
   int miscompares;

   vedic_8x8 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer multiplication of the operands.
   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
      int prod;
      prod = int'(x) * int'(y);
      return prod[15:0];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      a = 8'h40;
      b = 8'h30;
      #1;
      vectors++;
      if (result !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_immediate: got %h expected 0000", result);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (result !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got %h expected 0000", i, result);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (result !== 16'h0C00) begin
         miscompares++;
         $display("FAIL reset_release: got %h expected 0c00", result);
      end
   endtask

   task automatic test_directed();
      logic [7:0]  ta [9] = '{8'h40, 8'h30, 8'h20, 8'h13, 8'h00, 8'h01, 8'hFF, 8'h80, 8'hFF};
      logic [7:0]  tb_ [9] = '{8'h30, 8'h23, 8'h25, 8'h73, 8'hA5, 8'hB7, 8'hFF, 8'h80, 8'h01};
      logic [15:0] tp [9] = '{16'h0C00, 16'h0690, 16'h04A0, 16'h0889, 16'h0000,
                              16'h00B7, 16'hFE01, 16'h4000, 16'h00FF};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         a = ta[i];
         b = tb_[i];
         @(posedge clk);
         #1;
         vectors++;
         if (result !== tp[i]) begin
            miscompares++;
            $display("FAIL directed[%0d] %h*%h: got %h expected %h", i, ta[i], tb_[i], result, tp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] expected;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         expected = ref_mul(a, b);
         @(posedge clk);
         #1;
         vectors++;
         if (result !== expected) begin
            miscompares++;
            $display("FAIL pipeline[%0d] %h*%h: got %h expected %h", i, a, b, result, expected);
         end
         // Mid-cycle operand changes must not reach the registered output.
         #2;
         a = ~a;
         b = b + 8'd1;
         #1;
         vectors++;
         if (result !== expected) begin
            miscompares++;
            $display("FAIL hold_between_edges[%0d]: got %h expected %h", i, result, expected);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      a = 8'hFF;
      b = 8'hFF;
      @(posedge clk);
      #1;
      vectors++;
      if (result !== 16'hFE01) begin
         miscompares++;
         $display("FAIL async_pre: got %h expected fe01", result);
      end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (result !== 16'h0000) begin
         miscompares++;
         $display("FAIL async_assert: got %h expected 0000", result);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (result !== 16'h0000) begin
         miscompares++;
         $display("FAIL async_hold: got %h expected 0000", result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a = 8'h13;
      b = 8'h73;
      @(posedge clk);
      #1;
      vectors++;
      if (result !== 16'h0889) begin
         miscompares++;
         $display("FAIL async_release: got %h expected 0889", result);
      end
   endtask

   task automatic test_exhaustive();
      logic [15:0] expected;
      int          errs;
      errs = 0;
      for (int i = 0; i < 65536; i++) begin
         @(negedge clk);
         a = 8'(i >> 8);
         b = 8'(i);
         expected = ref_mul(a, b);
         @(posedge clk);
         #1;
         vectors++;
         if (result !== expected) begin
            miscompares++;
            errs++;
            if (errs <= 10) begin
               $display("FAIL exhaustive %h*%h: got %h expected %h", a, b, result, expected);
            end
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      a = 8'h00;
      b = 8'h00;
      test_reset();
      test_directed();
      test_back_to_back();
      test_async_reset();
      test_exhaustive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
